line_window3: RTL and testbench

LINE_WINDOW3 -- requirements
Module: line_window3

---
 rtl/line_window3.sv | 166 ++++++++++++++++
 tb/tb_line_window3.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window3.sv
// line_window3: 3x3 sliding-window generator for a raster pixel stream.
// Each 30-bit pixel carries three 10-bit channels. Two line buffers hold
// the previous two rows, a 3x3 shift array per channel forms the window,
// and one output register with valid/ready handshake presents it.
// Optional build macro LINE_WINDOW3_STRIDE2_EN: emit only the windows
// whose top-left corner lies on even row and column offsets (stride 2).
module line_window3 #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [29:0] i_data,
  output logic        o_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [89:0] o_busData0,
  output logic [89:0] o_busData1,
  output logic [89:0] o_busData2,
  output logic        o_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

`ifdef LINE_WINDOW3_STRIDE2_EN
  // Bottom-right pixel of the final stride-2 window in the frame.
  localparam logic [CW-1:0] LAST_COL = CW'(2 + ((IMG_W - 3) / 2) * 2);
  localparam logic [RW-1:0] LAST_ROW = RW'(2 + ((IMG_H - 3) / 2) * 2);
`else
  localparam logic [CW-1:0] LAST_COL = COL_MAX;
  localparam logic [RW-1:0] LAST_ROW = ROW_MAX;
`endif

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // line1 holds row r-1, line2 holds row r-2, indexed by column.
  logic [29:0] line1 [IMG_W];
  logic [29:0] line2 [IMG_W];
  logic [29:0] up1;
  logic [29:0] up2;

  // win[i][j]: i = window row (0 oldest), j = window column (0 leftmost).
  logic [29:0] win [3][3];
  logic [29:0] nxt [3][3];
  logic [89:0] bus_next [3];

  logic accept;
  logic emit;
  logic is_last;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign up1     = line1[col];
  assign up2     = line2[col];

`ifdef LINE_WINDOW3_STRIDE2_EN
  // (r-2) and (c-2) even is the same as r and c even.
  assign emit = accept && (row >= RW'(2)) && (col >= CW'(2)) && !row[0] && !col[0];
`else
  assign emit = accept && (row >= RW'(2)) && (col >= CW'(2));
`endif
  assign is_last = (row == LAST_ROW) && (col == LAST_COL);

  // Window as it will look once the current pixel's column is shifted in.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        nxt[i][j] = '0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      nxt[i][0] = win[i][1];
      nxt[i][1] = win[i][2];
    end
    nxt[0][2] = up2;
    nxt[1][2] = up1;
    nxt[2][2] = i_data;
  end

  // Pack the next window per channel: tap k = row*3+col.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      bus_next[ch] = '0;
    end
    for (int ch = 0; ch < 3; ch++) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          bus_next[ch][10*(i*3+j) +: 10] = nxt[i][j][10*ch +: 10];
        end
      end
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers: push the column down one row per accepted pixel.
  always_ff @(posedge i_clk) begin
    // NOTE: no reset on the line memories; rows r-1/r-2 are only read into an
    // emitted window once this frame has overwritten them, so stale content
    // never escapes and the arrays can map onto plain RAM.
    if (accept) begin
      line2[col] <= line1[col];
      line1[col] <= i_data;
    end
  end

  // Window shift array: move one column left per accepted pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= nxt[i][j];
        end
      end
    end
  end

  // Output register: load on an emitting accept, drop valid once consumed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_busData0 <= '0;
      o_busData1 <= '0;
      o_busData2 <= '0;
    end else if (emit) begin
      o_valid    <= 1'b1;
      o_last     <= is_last;
      o_busData0 <= bus_next[0];
      o_busData1 <= bus_next[1];
      o_busData2 <= bus_next[2];
    end else if (i_ready) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_window3.sv
// Testbench for line_window3: two instances (4x4 and 7x5) driven one at a
// time, with a frame-level reference model that stores the image and cuts
// windows straight out of it. Honours LINE_WINDOW3_STRIDE2_EN.
module tb_line_window3;

`ifdef LINE_WINDOW3_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif

  typedef struct packed {
    logic [89:0] b0;
    logic [89:0] b1;
    logic [89:0] b2;
    logic        last;
  } win_t;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic        vld  [2];
  logic        rdy  [2];
  logic        ordy [2];
  logic        ovld [2];
  logic        olast[2];
  logic [29:0] dat  [2];
  logic [89:0] b0   [2];
  logic [89:0] b1   [2];
  logic [89:0] b2   [2];

  always #5 clk = ~clk;

  line_window3 #(.IMG_W(4), .IMG_H(4)) dut_a (
    .i_clk(clk), .i_rst(rst[0]), .i_valid(vld[0]), .i_data(dat[0]),
    .o_ready(ordy[0]), .o_valid(ovld[0]), .i_ready(rdy[0]),
    .o_busData0(b0[0]), .o_busData1(b1[0]), .o_busData2(b2[0]),
    .o_last(olast[0])
  );

  line_window3 #(.IMG_W(7), .IMG_H(5)) dut_b (
    .i_clk(clk), .i_rst(rst[1]), .i_valid(vld[1]), .i_data(dat[1]),
    .o_ready(ordy[1]), .o_valid(ovld[1]), .i_ready(rdy[1]),
    .o_busData0(b0[1]), .o_busData1(b1[1]), .o_busData2(b2[1]),
    .o_last(olast[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          cur, wd, ht, mr, mc, dbase;
  logic [29:0] img [8][8];
  win_t        exp_q[$];
  int          vmode, rmode, bp_left, send_left, win_seen;
  logic        bp_done, data_rand, pend_ok;
  logic [29:0] pend;
  win_t        first_win, last_win;

  function automatic logic [29:0] pix_directed(int r, int c, int w, int base);
    logic [9:0] v;
    v = 10'(r * w + c + base);
    return {v + 10'd200, v + 10'd100, v};
  endfunction

  function automatic logic emits(int r, int c);
    return (r >= 2) && (c >= 2) && ((r - 2) % STRIDE == 0) && ((c - 2) % STRIDE == 0);
  endfunction

  function automatic int windows_per_frame(int w, int h);
    return ((w - 3) / STRIDE + 1) * ((h - 3) / STRIDE + 1);
  endfunction

  // One clock of stimulus plus scoreboard comparison of the DUT outputs.
  task automatic step();
    logic rv, vv, exp_v;
    win_t w;
    @(negedge clk);
    exp_v = (exp_q.size() != 0);
    case (rmode)
      0: rv = 1'b1;
      1: rv = ($urandom % 3) != 0;
      default: begin
        if (!bp_done && exp_v) begin
          bp_left = 5;
          bp_done = 1'b1;
        end
        if (bp_left > 0) begin
          rv = 1'b0;
          bp_left--;
        end else begin
          rv = 1'b1;
        end
      end
    endcase
    vv = (send_left > 0) && (vmode == 0 || ($urandom % 3) != 0);
    if (!pend_ok) begin
      pend = data_rand ? 30'($urandom) : pix_directed(mr, mc, wd, dbase);
      pend_ok = 1'b1;
    end
    vld[cur] = vv;
    dat[cur] = vv ? pend : 30'd0;
    rdy[cur] = rv;
    #1;
    n_checks++;
    if (ovld[cur] !== exp_v) begin
      n_fail++;
      $display("FAIL o_valid t=%0t got=%b exp=%b", $time, ovld[cur], exp_v);
    end
    n_checks++;
    if (ordy[cur] !== (!exp_v || rv)) begin
      n_fail++;
      $display("FAIL o_ready t=%0t got=%b exp=%b", $time, ordy[cur], !exp_v || rv);
    end
    if (exp_v) begin
      n_checks++;
      if (b0[cur] !== exp_q[0].b0) begin
        n_fail++;
        $display("FAIL bus0 t=%0t got=%h exp=%h", $time, b0[cur], exp_q[0].b0);
      end
      n_checks++;
      if (b1[cur] !== exp_q[0].b1) begin
        n_fail++;
        $display("FAIL bus1 t=%0t got=%h exp=%h", $time, b1[cur], exp_q[0].b1);
      end
      n_checks++;
      if (b2[cur] !== exp_q[0].b2) begin
        n_fail++;
        $display("FAIL bus2 t=%0t got=%h exp=%h", $time, b2[cur], exp_q[0].b2);
      end
      n_checks++;
      if (olast[cur] !== exp_q[0].last) begin
        n_fail++;
        $display("FAIL o_last t=%0t got=%b exp=%b", $time, olast[cur], exp_q[0].last);
      end
      if (rv) begin
        if (win_seen == 0) first_win = exp_q[0];
        last_win = exp_q[0];
        win_seen++;
        void'(exp_q.pop_front());
      end
    end
    if (vv && (!exp_v || rv)) begin
      img[mr][mc] = pend;
      pend_ok = 1'b0;
      if (emits(mr, mc)) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            w.b0[10*(i*3+j) +: 10] = img[mr-2+i][mc-2+j][9:0];
            w.b1[10*(i*3+j) +: 10] = img[mr-2+i][mc-2+j][19:10];
            w.b2[10*(i*3+j) +: 10] = img[mr-2+i][mc-2+j][29:20];
          end
        end
        w.last = (mr == 2 + ((ht - 3) / STRIDE) * STRIDE) &&
                 (mc == 2 + ((wd - 3) / STRIDE) * STRIDE);
        exp_q.push_back(w);
      end
      send_left--;
      mc++;
      if (mc == wd) begin
        mc = 0;
        mr++;
        if (mr == ht) begin
          mr = 0;
          dbase += wd * ht;
        end
      end
    end
  endtask

  task automatic select(int d, int v_mode, int r_mode, logic rnd);
    cur = d;
    wd = (d == 0) ? 4 : 7;
    ht = (d == 0) ? 4 : 5;
    vmode = v_mode;
    rmode = r_mode;
    data_rand = rnd;
    bp_done = 1'b0;
    bp_left = 0;
    win_seen = 0;
    dbase = 0;
    pend_ok = 1'b0;
  endtask

  // Feed n pixels, then drain outstanding windows; both phases bounded.
  task automatic run_pixels(int n);
    send_left = n;
    for (int i = 0; i < 20000 && send_left > 0; i++) step();
    n_checks++;
    if (send_left != 0) begin
      n_fail++;
      $display("FAIL feed_timeout got=%0d pixels_left exp=0", send_left);
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
    end
  endtask

  task automatic apply_reset(int d);
    @(negedge clk);
    rst[d] = 1'b1;
    vld[d] = 1'b0;
    rdy[d] = 1'b0;
    #1;
    n_checks++;
    if (ovld[d] !== 1'b0 || olast[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags dut=%0d got=%b%b exp=00", d, ovld[d], olast[d]);
    end
    n_checks++;
    if (b0[d] !== '0 || b1[d] !== '0 || b2[d] !== '0) begin
      n_fail++;
      $display("FAIL reset_bus dut=%0d got=%h/%h/%h exp=0", d, b0[d], b1[d], b2[d]);
    end
    @(negedge clk);
    rst[d] = 1'b0;
    exp_q.delete();
    mr = 0;
    mc = 0;
    pend_ok = 1'b0;
    #1;
    n_checks++;
    if (ordy[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready dut=%0d got=%b exp=1", d, ordy[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) apply_reset(d);
  endtask

  task automatic test_directed();
    int taps_first[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int taps_last[9]  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    win_t e_first, e_last;
    select(0, 0, 0, 1'b0);
    run_pixels(16);
    for (int k = 0; k < 9; k++) begin
      e_first.b0[10*k +: 10] = 10'(taps_first[k]);
      e_first.b1[10*k +: 10] = 10'(taps_first[k] + 100);
      e_first.b2[10*k +: 10] = 10'(taps_first[k] + 200);
      e_last.b0[10*k +: 10]  = 10'(taps_last[k]);
      e_last.b1[10*k +: 10]  = 10'(taps_last[k] + 100);
      e_last.b2[10*k +: 10]  = 10'(taps_last[k] + 200);
    end
    e_first.last = (STRIDE == 2);
    e_last.last  = 1'b1;
    if (STRIDE == 2) e_last = e_first;
    n_checks++;
    if (win_seen != 4 / (STRIDE * STRIDE)) begin
      n_fail++;
      $display("FAIL directed_count got=%0d exp=%0d", win_seen, 4 / (STRIDE * STRIDE));
    end
    n_checks++;
    if (first_win !== e_first) begin
      n_fail++;
      $display("FAIL directed_first got=%h exp=%h", first_win, e_first);
    end
    n_checks++;
    if (last_win !== e_last) begin
      n_fail++;
      $display("FAIL directed_last got=%h exp=%h", last_win, e_last);
    end
  endtask

  task automatic test_backpressure();
    select(0, 0, 2, 1'b0);
    run_pixels(16);
    n_checks++;
    if (win_seen != windows_per_frame(4, 4)) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=%0d", win_seen, windows_per_frame(4, 4));
    end
  endtask

  task automatic test_back_to_back();
    select(0, 0, 0, 1'b0);
    run_pixels(32);
    n_checks++;
    if (win_seen != 2 * windows_per_frame(4, 4)) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d exp=%0d", win_seen, 2 * windows_per_frame(4, 4));
    end
  endtask

  task automatic test_reset_mid();
    int cut[2] = '{7, 12};
    for (int t = 0; t < 2; t++) begin
      select(0, 0, 0, 1'b0);
      send_left = cut[t];
      for (int i = 0; i < 200 && send_left > 0; i++) step();
      apply_reset(0);
      select(0, 0, 0, 1'b0);
      run_pixels(16);
      n_checks++;
      if (win_seen != windows_per_frame(4, 4) || last_win.last !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_frame got=%0d/%b exp=%0d/1", win_seen, last_win.last,
                 windows_per_frame(4, 4));
      end
    end
  endtask

  task automatic test_random();
    select(1, 1, 1, 1'b1);
    run_pixels(10 * 7 * 5);
    n_checks++;
    if (win_seen != 10 * windows_per_frame(7, 5)) begin
      n_fail++;
      $display("FAIL random_count got=%0d exp=%0d", win_seen, 10 * windows_per_frame(7, 5));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      vld[d] = 1'b0;
      rdy[d] = 1'b0;
      dat[d] = '0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
